// File: rtl/dunit_dump_tx.sv
// dunit_dump_tx: dumps register file then data memory as a HEADER/words/TRAILER byte stream to a UART TX
module dunit_dump_tx #(
  parameter int NB_REG = 32,
  parameter int NB_BYTE = 8,
  parameter int N_REGS = 32,
  parameter int N_MEM_WORDS = 32,
  parameter logic [NB_BYTE-1:0] HEADER = 8'hA5,
  parameter logic [NB_BYTE-1:0] TRAILER = 8'h5A
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [NB_REG-1:0] i_reg_data,
  input  logic [NB_REG-1:0] i_mem_data,
  input  logic              i_tx_done,
  output logic [NB_REG-1:0] o_addr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_done
);
  localparam int NBYTES = NB_REG / NB_BYTE;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam int NMAX = N_REGS > N_MEM_WORDS ? N_REGS : N_MEM_WORDS;
  localparam int IW = NMAX > 1 ? $clog2(NMAX) : 1;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, NEXT, ADDR, SETTLE, LATCH, DONE} state_t;
  typedef enum logic [1:0] {HDR, REG, MEM, TRL} phase_t;
  state_t state_q;
  phase_t phase_q;
  logic [NB_REG-1:0] sr_q, addr_q;
  logic [BW-1:0] byte_q;
  logic [IW-1:0] idx_q;
  logic [NB_BYTE-1:0] tx_data_q;
  logic tx_start_q, busy_q, done_q;
  assign o_addr = addr_q;
  assign o_tx_data = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      phase_q <= HDR;
      sr_q <= '0;
      addr_q <= '0;
      byte_q <= '0;
      idx_q <= '0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_start) begin
          busy_q <= 1'b1;
          phase_q <= HDR;
          sr_q <= NB_REG'(HEADER) << (NB_REG - NB_BYTE);
          state_q <= SEND;
        end
        SEND: begin
          tx_data_q <= sr_q[NB_REG-1 -: NB_BYTE];
          tx_start_q <= 1'b1;
          state_q <= WAIT;
        end
        // a done coinciding with our own start pulse belongs to no byte of ours
        WAIT: begin
          tx_start_q <= 1'b0;
          if (i_tx_done && !tx_start_q) state_q <= NEXT;
        end
        NEXT: begin
          if (phase_q == HDR) begin
            phase_q <= REG;
            idx_q <= '0;
            byte_q <= '0;
            state_q <= ADDR;
          end else if (phase_q == TRL) begin
            done_q <= 1'b1;
            state_q <= DONE;
          end else if (byte_q != BW'(NBYTES - 1)) begin
            sr_q <= sr_q << NB_BYTE;
            byte_q <= byte_q + BW'(1);
            state_q <= SEND;
          end else begin
            byte_q <= '0;
            if (phase_q == REG && idx_q == IW'(N_REGS - 1)) begin
              phase_q <= MEM;
              idx_q <= '0;
              state_q <= ADDR;
            end else if (phase_q == MEM && idx_q == IW'(N_MEM_WORDS - 1)) begin
              phase_q <= TRL;
              sr_q <= NB_REG'(TRAILER) << (NB_REG - NB_BYTE);
              state_q <= SEND;
            end else begin
              idx_q <= idx_q + IW'(1);
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          addr_q <= NB_REG'(idx_q);
          state_q <= SETTLE;
        end
        SETTLE: state_q <= LATCH;
        LATCH: begin
          sr_q <= phase_q == MEM ? i_mem_data : i_reg_data;
          byte_q <= '0;
          state_q <= SEND;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dunit_dump_tx.sv
// tb_dunit_dump_tx: random-delay UART TX and sync-read memories around dunit_dump_tx, checked against a byte-stream model
module tb_dunit_dump_tx;
  localparam int NR = 32, NM = 32, NBYTES = 4, FRAME = 2 + NBYTES * (NR + NM);
  logic i_clk = 1'b0, i_reset, i_start, i_tx_done;
  logic [31:0] i_reg_data, i_mem_data, o_addr;
  logic [7:0] o_tx_data;
  logic o_tx_start, o_busy, o_done;
  dunit_dump_tx dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_tx_done(i_tx_done),
    .o_addr(o_addr), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_done(o_done)
  );
  always #5 i_clk = ~i_clk;
  logic [31:0] regs [NR];
  logic [31:0] mems [NM];
  always @(posedge i_clk) begin
    i_reg_data <= regs[o_addr[4:0]];
    i_mem_data <= mems[o_addr[4:0]];
  end
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$], got_q[$];
  logic [7:0] cur;
  bit waiting = 0, exp_busy = 0, stray_en = 0, same_stray = 0;
  int cnt = 0, done_at = -10, cyc = 0, frames = 0, dly_lo = 10, dly_hi = 10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_frame();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < NR; k++)
      for (int b = NBYTES - 1; b >= 0; b--) exp_q.push_back(regs[k][8*b +: 8]);
    for (int k = 0; k < NM; k++)
      for (int b = NBYTES - 1; b >= 0; b--) exp_q.push_back(mems[k][8*b +: 8]);
    exp_q.push_back(8'h5A);
  endtask

  initial begin
    bit tx;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_reset) begin
        chk("busy", o_busy, exp_busy);
        chk("done", o_done, cyc == done_at);
        chk("addr_range", o_addr < NM, 1);
        if (o_tx_start) begin
          if (waiting || exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL tx_start: unexpected pulse with data %h (cycle %0d)", o_tx_data, cyc);
          end else begin
            cur = exp_q.pop_front();
            got_q.push_back(o_tx_data);
            chk("tx_byte", o_tx_data, cur);
          end
        end else if (waiting) chk("tx_hold", o_tx_data, cur);
        if (cyc == done_at) begin
          chk("frame_len", got_q.size(), FRAME);
          chk("addr_end", o_addr, NM - 1);
          frames++;
        end
      end
      tx = 1'b0;
      if (cnt > 0) begin
        cnt--;
        tx = cnt == 0;
      end
      if (!i_reset && o_tx_start) begin
        cnt = $urandom_range(dly_hi, dly_lo);
        if (same_stray) tx = $urandom_range(1, 0) == 1;
      end
      if (stray_en) tx = $urandom_range(3, 0) == 0;
      i_tx_done = tx;
      if (i_reset) begin
        exp_q.delete();
        waiting = 0;
        exp_busy = 0;
        cnt = 0;
        done_at = -10;
      end else begin
        if (waiting && i_tx_done) begin
          waiting = 0;
          if (exp_q.size() == 0 && exp_busy) done_at = cyc + 2;
        end
        if (o_tx_start) waiting = 1;
        if (cyc == done_at) exp_busy = 0;
        else if (i_start && !exp_busy) begin
          exp_busy = 1;
          got_q.delete();
          build_frame();
        end
      end
    end
  end

  task automatic start_pulse();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 60000) begin
      @(posedge i_clk);
      t++;
    end
    if (frames < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_timeout: frames %0d required %0d", frames, n);
    end
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (got_q.size() < n && t < 60000) begin
      @(posedge i_clk);
      t++;
    end
    if (got_q.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_timeout: bytes %0d required %0d", got_q.size(), n);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, o_addr, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
    chk({tag, "_tx_start"}, o_tx_start, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    int t;
    i_reset = 1'b1;
    i_start = 1'b0;
    for (int k = 0; k < NR; k++) regs[k] = 32'h01010101 * k;
    for (int k = 0; k < NM; k++) mems[k] = 32'hC0DE0000 + k;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    chk_zero("reset");
    stray_en = 1;
    repeat (20) @(posedge i_clk);
    #1 stray_en = 0;
    repeat (2) @(posedge i_clk);
    #1 chk_zero("idle");
    start_pulse();
    wait_frames(1);
    chk("lit_header", got_q[0], 8'hA5);
    chk("lit_reg0", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'h0);
    chk("lit_reg1_msb", got_q[5], 8'h01);
    chk("lit_reg31_lsb", got_q[128], 8'h1F);
    chk("lit_mem0_msb", got_q[129], 8'hC0);
    chk("lit_mem31", {got_q[253], got_q[254], got_q[255], got_q[256]}, 32'hC0DE001F);
    chk("lit_trailer", got_q[257], 8'h5A);
    repeat (3) @(posedge i_clk);
    #1 chk("post_busy", o_busy, 0);
    chk("post_addr", o_addr, 31);
    dly_lo = 1;
    dly_hi = 200;
    same_stray = 1;
    start_pulse();
    wait_frames(2);
    dly_lo = 1;
    dly_hi = 4;
    start_pulse();
    wait_bytes(5);
    start_pulse();
    wait_bytes(100);
    start_pulse();
    t = 0;
    while (t < 20000) begin
      @(posedge i_clk);
      #1;
      t++;
      if (o_done) break;
    end
    chk("done_seen", o_done, 1);
    i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (300) @(posedge i_clk);
    chk("single_frame", frames, 3);
    for (int k = 0; k < NR; k++) regs[k] = $urandom;
    for (int k = 0; k < NM; k++) mems[k] = $urandom;
    dly_lo = 1;
    dly_hi = 3;
    start_pulse();
    wait_bytes(1 + NBYTES * NR + 2 * NBYTES + 2);
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk); #1 i_reset = 1'b0;
    chk_zero("midreset");
    repeat (10) @(posedge i_clk);
    #1 chk_zero("after_reset");
    start_pulse();
    wait_frames(4);
    chk("rst_header", got_q[0], 8'hA5);
    chk("rst_reg0", {got_q[1], got_q[2], got_q[3], got_q[4]}, regs[0]);
    chk("rst_len", got_q.size(), FRAME);
    repeat (5) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
